mpf_mmio_rsp_arb: RTL and testbench

- Merges MMIO read responses from N independent response FIFOs into the single host MMIO read-response channel. Sources include the VTP CSR service FIFO and AFU CSR handlers.
- Uses fair round-robin arbitration with one registered output stage.
- Tracks outstanding host MMIO reads so that upstream logic can throttle reads before any response FIFO can overflow.
- Sits between the MMIO response FIFOs and the host-facing MMIO TX channel.

---
 rtl/mpf_mmio_rsp_arb_if.sv | 43 ++++
 rtl/mpf_mmio_rsp_arb.sv | 128 ++++++++++++
 tb/tb_mpf_mmio_rsp_arb.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mpf_mmio_rsp_arb_if.sv
// MMIO read-response arbiter bus: source FIFO heads, merged host response
// channel and outstanding-read tracking signals.
interface mpf_mmio_rsp_arb_if #(
  parameter int N_SRC           = 2,
  parameter int TID_WIDTH       = 9,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 64
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Source FIFO side
  logic [N_SRC-1:0]            src_rsp_valid;
  logic [N_SRC*TID_WIDTH-1:0]  src_rsp_tid;
  logic [N_SRC*DATA_WIDTH-1:0] src_rsp_data;
  logic [N_SRC-1:0]            src_rsp_deq;

  // Host response side
  logic                        rsp_valid;
  logic [TID_WIDTH-1:0]        rsp_tid;
  logic [DATA_WIDTH-1:0]       rsp_data;
  logic                        rsp_ready;

  // Outstanding read tracking
  logic                        rd_req;
  logic                        rd_req_ready;
  logic [CNT_W-1:0]            outstanding;
  logic                        err_overflow;
  logic                        err_underflow;

  // Environment view: source FIFOs, host consumer and read-request issuer
  modport master (
    output src_rsp_valid, src_rsp_tid, src_rsp_data, rsp_ready, rd_req,
    input  src_rsp_deq, rsp_valid, rsp_tid, rsp_data,
           rd_req_ready, outstanding, err_overflow, err_underflow
  );

  // Arbiter view
  modport slave (
    input  src_rsp_valid, src_rsp_tid, src_rsp_data, rsp_ready, rd_req,
    output src_rsp_deq, rsp_valid, rsp_tid, rsp_data,
           rd_req_ready, outstanding, err_overflow, err_underflow
  );
endinterface

// File: rtl/mpf_mmio_rsp_arb.sv
// Round-robin merge of N MMIO read-response FIFOs into one registered host
// response channel, plus an in-flight read counter for upstream throttling.
module mpf_mmio_rsp_arb #(
  parameter int N_SRC           = 2,
  parameter int TID_WIDTH       = 9,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mpf_mmio_rsp_arb_if.slave     bus
);
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_SRC - 1);

  logic                  rsp_valid_q, rsp_valid_d;
  logic [TID_WIDTH-1:0]  rsp_tid_q,   rsp_tid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [PTR_W-1:0]      rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  err_ovf_q,   err_ovf_d;
  logic                  err_unf_q,   err_unf_d;

  logic                  load_ok;
  logic                  hs;
  logic                  cand_vld;
  logic [PTR_W-1:0]      cand_idx;
  logic [TID_WIDTH-1:0]  cand_tid;
  logic [DATA_WIDTH-1:0] cand_data;
  logic                  grant_vld;
  logic [N_SRC-1:0]      deq;

  assign load_ok = !rsp_valid_q || bus.rsp_ready;
  assign hs      = rsp_valid_q && bus.rsp_ready;

  // First valid source at or after rr_ptr, wrapping modulo N_SRC
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cand_vld  = 1'b0;
    cand_idx  = '0;
    cand_tid  = '0;
    cand_data = '0;
    for (int off = 0; off < N_SRC; off++) begin
      int idx;
      idx = (int'(rr_ptr_q) + off) % N_SRC;
      if (!cand_vld && bus.src_rsp_valid[idx]) begin
        cand_vld  = 1'b1;
        cand_idx  = PTR_W'(idx);
        cand_tid  = bus.src_rsp_tid[idx*TID_WIDTH +: TID_WIDTH];
        cand_data = bus.src_rsp_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Grant only when the output register can take the head; never pop in reset
  always_comb begin
    grant_vld = cand_vld && load_ok && reset_n;
    deq       = '0;
    if (grant_vld) deq[cand_idx] = 1'b1;
  end

  // Output register and round-robin pointer next state
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_tid_d   = rsp_tid_q;
    rsp_data_d  = rsp_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_vld) begin
      rsp_valid_d = 1'b1;
      rsp_tid_d   = cand_tid;
      rsp_data_d  = cand_data;
      rr_ptr_d    = (cand_idx == LAST_IDX) ? '0 : cand_idx + PTR_W'(1);
    end else if (hs) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Outstanding counter with saturation and sticky error capture
  always_comb begin
    cnt_d     = cnt_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    unique case ({bus.rd_req, hs})
      2'b10: begin
        if (cnt_q == MAX_CNT) err_ovf_d = 1'b1;
        else                  cnt_d     = cnt_q + CNT_W'(1);
      end
      2'b01: begin
        if (cnt_q == '0) err_unf_d = 1'b1;
        else             cnt_d     = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // State registers; an asserted reset discards any held response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
    end
  end

  assign bus.src_rsp_deq   = deq;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_tid       = rsp_tid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rd_req_ready  = (cnt_q < MAX_CNT);
  assign bus.outstanding   = cnt_q;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_underflow = err_unf_q;
endmodule

// File: tb/tb_mpf_mmio_rsp_arb.sv
// Directed bench for mpf_mmio_rsp_arb with two queue-backed source FIFOs.
module tb_mpf_mmio_rsp_arb;
  localparam int N_SRC = 2;
  localparam int TW    = 9;
  localparam int DW    = 64;
  localparam int MAXO  = 64;

  typedef struct packed {
    logic [TW-1:0] tid;
    logic [DW-1:0] data;
  } ent_t;

  logic clk;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;
  ent_t q0[$];
  ent_t q1[$];
  logic [N_SRC-1:0] deq_snap;

  mpf_mmio_rsp_arb_if #(.N_SRC(N_SRC), .TID_WIDTH(TW), .DATA_WIDTH(DW),
                        .MAX_OUTSTANDING(MAXO)) bus ();

  mpf_mmio_rsp_arb #(.N_SRC(N_SRC), .TID_WIDTH(TW), .DATA_WIDTH(DW),
                     .MAX_OUTSTANDING(MAXO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [TW-1:0] tid);
    ent_t e;
    e.tid  = tid;
    e.data = {55'h0, tid} ^ 64'hA5A5_0000_1234_0000;
    return e;
  endfunction

  // Drive source heads from the queue models
  task automatic present();
    bus.src_rsp_valid = {q1.size() > 0, q0.size() > 0};
    bus.src_rsp_tid   = '0;
    bus.src_rsp_data  = '0;
    if (q0.size() > 0) begin
      bus.src_rsp_tid[0 +: TW]  = q0[0].tid;
      bus.src_rsp_data[0 +: DW] = q0[0].data;
    end
    if (q1.size() > 0) begin
      bus.src_rsp_tid[TW +: TW]  = q1[0].tid;
      bus.src_rsp_data[DW +: DW] = q1[0].data;
    end
  endtask

  // One clock: capture pops, pass the edge, retire popped heads
  task automatic step();
    #1 deq_snap = bus.src_rsp_deq;
    @(posedge clk);
    #1;
    if (deq_snap[0] && q0.size() > 0) void'(q0.pop_front());
    if (deq_snap[1] && q1.size() > 0) void'(q1.pop_front());
    present();
    #1;
  endtask

  // Reset with both sources claiming valid; checks the reset state
  task automatic do_reset();
    q0.delete();
    q1.delete();
    reset_n = 1'b0;
    bus.src_rsp_valid = 2'b11;
    bus.src_rsp_tid   = {9'h1AA, 9'h155};
    bus.src_rsp_data  = {64'h1111, 64'h2222};
    #1;
    check("rst_async_valid", bus.rsp_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_deq", bus.src_rsp_deq, 0);
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_tid", bus.rsp_tid, 0);
    check("rst_data", bus.rsp_data, 0);
    check("rst_outstanding", bus.outstanding, 0);
    check("rst_rd_req_ready", bus.rd_req_ready, 1);
    check("rst_err_ovf", bus.err_overflow, 0);
    check("rst_err_unf", bus.err_underflow, 0);
    present();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    bus.rsp_ready = 1'b1;
    bus.rd_req    = 1'b0;
    present();

    // 1. Reset
    do_reset();

    // 2. Single source, one transaction
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check("t2_outstanding_1", bus.outstanding, 1);
    q0.push_back('{tid: 9'h005, data: 64'hDEAD_BEEF});
    present();
    #1;
    check("t2_deq_src0", bus.src_rsp_deq, 2'b01);
    step();
    check("t2_valid", bus.rsp_valid, 1);
    check("t2_tid", bus.rsp_tid, 9'h005);
    check("t2_data", bus.rsp_data, 64'hDEAD_BEEF);
    check("t2_deq_once", bus.src_rsp_deq, 0);
    step();
    check("t2_drained", bus.rsp_valid, 0);
    check("t2_outstanding_0", bus.outstanding, 0);
    check("t2_no_unf", bus.err_underflow, 0);

    // 3. Round-robin, four entries per source, no bubbles
    do_reset();
    bus.rd_req = 1'b1;
    repeat (10) step();
    bus.rd_req = 1'b0;
    check("t3_outstanding_10", bus.outstanding, 10);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(9'(9'h010 + i)));
      q1.push_back(mk(9'(9'h020 + i)));
    end
    present();
    for (int k = 0; k < 8; k++) begin
      logic [TW-1:0] exp_tid;
      ent_t          exp_e;
      exp_tid = (k % 2 == 0) ? 9'(9'h010 + k / 2) : 9'(9'h020 + k / 2);
      exp_e   = mk(exp_tid);
      step();
      check($sformatf("t3_valid_%0d", k), bus.rsp_valid, 1);
      check($sformatf("t3_tid_%0d", k), bus.rsp_tid, exp_tid);
      check($sformatf("t3_data_%0d", k), bus.rsp_data, exp_e.data);
    end
    step();
    check("t3_drained", bus.rsp_valid, 0);
    check("t3_outstanding_2", bus.outstanding, 2);
    q0.push_back(mk(9'h030));
    q1.push_back(mk(9'h040));
    present();
    #1;
    check("t3_rr_ptr_back_to_0", bus.src_rsp_deq, 2'b01);
    q0.delete();
    q1.delete();
    present();

    // 4. Backpressure on a held response
    bus.rsp_ready = 1'b0;
    q1.push_back('{tid: 9'h051, data: 64'hA1A1_A1A1_0000_0001});
    q1.push_back('{tid: 9'h052, data: 64'hA2A2_A2A2_0000_0002});
    present();
    #1;
    check("t4_first_deq", bus.src_rsp_deq, 2'b10);
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_hold_valid_%0d", k), bus.rsp_valid, 1);
      check($sformatf("t4_hold_tid_%0d", k), bus.rsp_tid, 9'h051);
      check($sformatf("t4_hold_data_%0d", k), bus.rsp_data, 64'hA1A1_A1A1_0000_0001);
      check($sformatf("t4_hold_deq_%0d", k), bus.src_rsp_deq, 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t4_reload_deq", bus.src_rsp_deq, 2'b10);
    step();
    check("t4_reload_valid", bus.rsp_valid, 1);
    check("t4_reload_tid", bus.rsp_tid, 9'h052);
    check("t4_reload_data", bus.rsp_data, 64'hA2A2_A2A2_0000_0002);
    check("t4_outstanding_1", bus.outstanding, 1);
    step();
    check("t4_drained", bus.rsp_valid, 0);
    check("t4_outstanding_0", bus.outstanding, 0);

    // 5. Counter saturation, overflow, simultaneous rd_req + handshake
    bus.rd_req = 1'b1;
    repeat (64) step();
    bus.rd_req = 1'b0;
    check("t5_outstanding_64", bus.outstanding, 64);
    check("t5_rd_req_ready_0", bus.rd_req_ready, 0);
    check("t5_no_ovf_yet", bus.err_overflow, 0);
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check("t5_ovf_set", bus.err_overflow, 1);
    check("t5_saturated", bus.outstanding, 64);
    q0.push_back(mk(9'h066));
    present();
    step();
    check("t5_loaded", bus.rsp_valid, 1);
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check("t5_both_unchanged", bus.outstanding, 64);
    check("t5_handshake_done", bus.rsp_valid, 0);
    check("t5_ovf_sticky", bus.err_overflow, 1);

    // 6. Underflow stickiness, reset mid-transfer
    do_reset();
    q0.push_back(mk(9'h077));
    present();
    step();
    check("t6_loaded", bus.rsp_valid, 1);
    step();
    check("t6_unf_set", bus.err_underflow, 1);
    check("t6_outstanding_0", bus.outstanding, 0);
    repeat (2) step();
    check("t6_unf_sticky", bus.err_underflow, 1);
    bus.rsp_ready = 1'b0;
    q0.push_back(mk(9'h078));
    present();
    step();
    check("t6_held_before_reset", bus.rsp_valid, 1);
    do_reset();
    bus.rsp_ready = 1'b1;
    step();
    check("t6_idle_after_reset", bus.rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
